// File: rtl/imem_program_loader_if.sv
// Host byte stream (v/stall) and instruction-memory A/W/D write port of the program loader.
// The host drives v_i/byte_i and observes stall_o; the loader drives the memory write pins.
interface imem_program_loader_if #(
    parameter int unsigned WORD = 32,
    parameter int unsigned ADDR = 16
) ();
    logic            v_i;
    logic [7:0]      byte_i;
    logic            stall_o;
    logic [ADDR-1:0] mem_a_o;
    logic            mem_w_o;
    logic [WORD-1:0] mem_d_o;

    modport master (
        output v_i,
        output byte_i,
        input  stall_o,
        input  mem_a_o,
        input  mem_w_o,
        input  mem_d_o
    );

    modport slave (
        input  v_i,
        input  byte_i,
        output stall_o,
        output mem_a_o,
        output mem_w_o,
        output mem_d_o
    );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed big-endian program into instruction memory over a v/stall byte stream,
// holding the core in reset until the last word has been written.
module imem_program_loader #(
    parameter int unsigned WORD      = 32,
    parameter int unsigned ADDR      = 16,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_program_loader_if.slave  bus,
    output logic                  core_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    typedef enum logic [1:0] {StHdr, StLoad, StDone, StErr} state_e;

    state_e          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     word_cnt_q, word_cnt_d;
    logic [31:0]     word_cnt_inc;
    logic [31:0]     assembled;
    logic [ADDR-1:0] mem_a_q, mem_a_d;
    logic            mem_w_q, mem_w_d;
    logic [WORD-1:0] mem_d_q, mem_d_d;
    logic            core_rel_q, core_rel_d;
    logic            accept;

    assign bus.stall_o  = !reset || (state_q == StDone) || (state_q == StErr);
    assign accept       = bus.v_i && !bus.stall_o;
    assign assembled    = {shift_q, bus.byte_i};
    assign word_cnt_inc = word_cnt_q + 32'd1;

    assign bus.mem_a_o  = mem_a_q;
    assign bus.mem_w_o  = mem_w_q;
    assign bus.mem_d_o  = mem_d_q;
    assign core_reset_o = core_rel_q;
    assign busy_o       = (state_q == StLoad) || ((state_q == StHdr) && (byte_cnt_q != 2'd0));
    assign done_o       = (state_q == StDone);
    assign err_o        = (state_q == StErr);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        mem_w_d    = 1'b0;
        // Release lags DONE by one edge so it follows the final write pulse.
        core_rel_d = (state_q == StDone);

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = assembled[23:0];
            if (byte_cnt_q == 2'd3) begin
                case (state_q)
                    StHdr: begin
                        len_d      = assembled;
                        word_cnt_d = 32'd0;
                        if (assembled == 32'd0) begin
                            state_d = StDone;
                        end else if (assembled > MAX_WORDS) begin
                            state_d = StErr;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                    StLoad: begin
                        mem_w_d    = 1'b1;
                        mem_a_d    = word_cnt_q[ADDR-1:0];
                        mem_d_d    = assembled;
                        word_cnt_d = word_cnt_inc;
                        if (word_cnt_inc == len_q) begin
                            state_d = StDone;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StHdr;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            len_q      <= 32'd0;
            word_cnt_q <= 32'd0;
            mem_a_q    <= '0;
            mem_w_q    <= 1'b0;
            mem_d_q    <= '0;
            core_rel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            mem_a_q    <= mem_a_d;
            mem_w_q    <= mem_w_d;
            mem_d_q    <= mem_d_d;
            core_rel_q <= core_rel_d;
        end
    end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory port. The fetch stage only ever reads that port.
- Receives a byte stream from a host through the codebase's v/stall handshake and assembles big-endian 32-bit words.
- Writes those words into mem_instruction through its A/W/D pins.
- Holds the core in reset until the program is fully loaded, then releases it.

Parameters:
WORD, 32, instruction word width (fixed at 4 bytes)
ADDR, 16, instruction memory address width
MAX_WORDS, 4096, largest accepted program length in words

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-low reset; sampled on posedge clk only
v_i  input  1  host byte valid
byte_i  input  8  host byte data
stall_o  output  1  loader cannot accept a byte this cycle
mem_a_o  output  ADDR  instruction memory address (to A)
mem_w_o  output  1  instruction memory write enable (to W)
mem_d_o  output  WORD  instruction memory write data (to D)
core_reset_o  output  1  active-low reset for fetch/decode/execute/register; 0 holds the core
busy_o  output  1  load in progress
done_o  output  1  program loaded, core released
err_o  output  1  header length exceeded MAX_WORDS

Behaviour:
- Handshake: a byte is accepted on a posedge where v_i=1 and stall_o=0. v_i=0 cycles are bubbles and change nothing.
- Byte order: the first byte of each group of 4 is bits [31:24]; the fourth byte is bits [7:0].
- Reset (reset=0 at posedge) forces:
  - state=HDR, byte_cnt=0, word_cnt=0
  - mem_w_o=0, mem_a_o=0, mem_d_o=0
  - core_reset_o=0, busy_o=0, done_o=0, err_o=0
  - stall_o=1 while reset is low
- Reset applies identically mid-load. Words already written stay in memory.
- States:
  - HDR: collect 4 bytes into length N.
    - On the 4th byte: N=0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> LOAD with word_cnt=0.
    - busy_o=1 once the first header byte has been accepted.
  - LOAD: collect 4 bytes per word.
    - On the posedge that accepts the 4th byte, register mem_d_o=assembled word, mem_a_o=word_cnt[ADDR-1:0], mem_w_o=1. The write pulse lasts exactly one cycle, is never held, and is not back-pressured.
    - word_cnt increments on the same edge.
    - If the incremented count equals N, go to DONE; otherwise stay in LOAD with byte_cnt=0.
    - The next byte may be accepted in the write-pulse cycle, so full throughput is 1 byte/cycle.
  - DONE: stall_o=1, busy_o=0, done_o=1.
    - core_reset_o goes to 1 on the posedge after the last mem_w_o pulse, i.e. on the edge after entering DONE when N>0.
    - Incoming bytes are ignored. The loader leaves DONE only through reset.
  - ERR: stall_o=1, err_o=1, busy_o=0, core_reset_o stays 0, nothing is written. Leaves only through reset.
- stall_o=0 in HDR and LOAD; 1 in DONE and ERR.
- Latency: 4th byte of word k accepted at edge t -> mem_w_o=1 during cycle t..t+1 with mem_a_o=k.
- Counter widths: byte_cnt is 2 bits; word_cnt is 32 bits, compared against the 32-bit N; mem_a_o takes the low ADDR bits of word_cnt.
- Boundary: N=MAX_WORDS is legal, and its last write lands at address MAX_WORDS-1.

Test Plan:
1. Reset low 2 cycles, then stream 00 00 00 02 | 12 34 56 78 | 9A BC DE F0 with v_i=1 continuously -> two write pulses: A=0, D=12345678 and A=1, D=9ABCDEF0. done_o=1 after the second pulse, core_reset_o=1 one cycle after it, stall_o=1 thereafter.
2. Same stream with v_i=0 bubbles inserted between every byte -> identical writes, and mem_w_o only pulses on the edge after a 4th byte.
3. Header 00 00 00 00 -> no mem_w_o pulse, done_o=1 and core_reset_o=1. Further bytes AA BB are ignored and no writes occur.
4. Header 00 00 10 01 (4097 > MAX_WORDS) -> err_o=1, stall_o=1, core_reset_o=0, no writes.
5. Header N=3, one full word, then reset low for 1 cycle mid-second word -> state back to HDR, core_reset_o=0, busy_o=0. A fresh N=1 load then writes to A=0.
6. N=MAX_WORDS with incrementing data -> last pulse at A=4095 with D=4095, then done_o=1.
